// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage store path: size codes, FSM states and
// small decode helpers used by the store unit and its lane merger.
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } store_state_e;

   // Code 2'b10 is not a real size; it is handled as a full word.
   function automatic logic size_is_word(input logic [1:0] size);
      return (size != SZ_BYTE) && (size != SZ_HALF);
   endfunction

   function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      if (size == SZ_HALF) bad = lane[0];
      else if (size_is_word(size)) bad = (lane != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/mem_store_unit_if.sv
// Pipeline/memory bundle of the store unit. The o_MEM_AddrErr signal only
// exists when MEM_ALIGN_CHECK_EN is defined.
interface mem_store_unit_if #(
   parameter int NBITS    = 32,
   parameter int ADDRBITS = 10,
   parameter int TNBITS   = 2
);
   logic                i_MEM_Store;
   logic [TNBITS-1:0]   i_MEM_SizeFiltroS;
   logic [NBITS-1:0]    i_MEM_Addr;
   logic [NBITS-1:0]    i_MEM_Data;
   logic [NBITS-1:0]    i_MEM_MemData;
   logic [ADDRBITS-1:0] o_MEM_Addr;
   logic                o_MEM_ReadEn;
   logic                o_MEM_WriteEn;
   logic [NBITS-1:0]    o_MEM_WriteData;
   logic                o_MEM_Stall;
   logic                o_MEM_Done;
`ifdef MEM_ALIGN_CHECK_EN
   logic                o_MEM_AddrErr;
`endif

   modport master (
`ifdef MEM_ALIGN_CHECK_EN
      input  o_MEM_AddrErr,
`endif
      output i_MEM_Store, i_MEM_SizeFiltroS, i_MEM_Addr, i_MEM_Data, i_MEM_MemData,
      input  o_MEM_Addr, o_MEM_ReadEn, o_MEM_WriteEn, o_MEM_WriteData, o_MEM_Stall, o_MEM_Done
   );

   modport slave (
`ifdef MEM_ALIGN_CHECK_EN
      output o_MEM_AddrErr,
`endif
      input  i_MEM_Store, i_MEM_SizeFiltroS, i_MEM_Addr, i_MEM_Data, i_MEM_MemData,
      output o_MEM_Addr, o_MEM_ReadEn, o_MEM_WriteEn, o_MEM_WriteData, o_MEM_Stall, o_MEM_Done
   );

endinterface

// File: rtl/store_lane_merge.sv
// Combinational sub-word merge: replaces the addressed byte/half lane of the
// old memory word with the LSBs of the store data (little-endian lanes).
module store_lane_merge
   import mips_mem_pkg::*;
#(
   parameter int NBITS     = 32,
   parameter int BYTENBITS = 8,
   parameter int HWORDBITS = 16,
   parameter int TNBITS    = 2
) (
   input  logic [NBITS-1:0]  i_old_word,
   input  logic [NBITS-1:0]  i_new_data,
   input  logic [TNBITS-1:0] i_size,
   input  logic [1:0]        i_lane,
   output logic [NBITS-1:0]  o_merged
);

   always_comb begin
      o_merged = i_old_word;
      case (i_size)
         SZ_BYTE: o_merged[BYTENBITS*int'(i_lane) +: BYTENBITS] = i_new_data[BYTENBITS-1:0];
         SZ_HALF: o_merged[HWORDBITS*int'(i_lane[1]) +: HWORDBITS] = i_new_data[HWORDBITS-1:0];
         default: o_merged = i_new_data;
      endcase
   end

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store writer for a word-wide memory without byte enables; sub-word
// stores are read-modify-write. Optional feature macro: MEM_ALIGN_CHECK_EN.
//
//  state | meaning
//  IDLE  | waiting for a store; latches addr/data/size on accept
//  READ  | ReadEn strobe to fetch the word holding the target lane
//  MERGE | WriteEn with the read word and the new lane spliced in
//  WRITE | WriteEn with the latched full word
//  DONE  | Done pulse; pipeline stall released
module mem_store_unit
   import mips_mem_pkg::*;
#(
   parameter int NBITS     = 32,
   parameter int BYTENBITS = 8,
   parameter int HWORDBITS = 16,
   parameter int ADDRBITS  = 10,
   parameter int TNBITS    = 2
) (
   input logic          i_clk,
   input logic          i_reset,
   mem_store_unit_if.slave mem
);

   store_state_e        state_q, state_d;
   logic [ADDRBITS+1:0] addr_q, addr_d;
   logic [NBITS-1:0]    data_q, data_d;
   logic [TNBITS-1:0]   size_q, size_d;
   logic                read_en_q, read_en_d;
   logic                write_en_q, write_en_d;
   logic                done_q, done_d;
   logic                addr_err_q, addr_err_d;
   logic                req_bad;
   logic [NBITS-1:0]    merged;
   logic [NBITS-1:0]    write_data;
   logic                unused_addr_hi;

   assign unused_addr_hi = ^mem.i_MEM_Addr[NBITS-1:ADDRBITS+2];

`ifdef MEM_ALIGN_CHECK_EN
   assign req_bad = addr_misaligned(mem.i_MEM_SizeFiltroS, mem.i_MEM_Addr[1:0]);
`else
   assign req_bad = 1'b0;
`endif

   store_lane_merge #(
      .NBITS     (NBITS),
      .BYTENBITS (BYTENBITS),
      .HWORDBITS (HWORDBITS),
      .TNBITS    (TNBITS)
   ) u_merge (
      .i_old_word (mem.i_MEM_MemData),
      .i_new_data (data_q),
      .i_size     (size_q),
      .i_lane     (addr_q[1:0]),
      .o_merged   (merged)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      size_d     = size_q;
      addr_err_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mem.i_MEM_Store) begin
               addr_d = mem.i_MEM_Addr[ADDRBITS+1:0];
               data_d = mem.i_MEM_Data;
               size_d = mem.i_MEM_SizeFiltroS;
               if (req_bad) begin
                  state_d    = ST_DONE;
                  addr_err_d = 1'b1;
               end else if (size_is_word(mem.i_MEM_SizeFiltroS)) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ:  state_d = ST_MERGE;
         ST_MERGE: state_d = ST_DONE;
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Strobes are registered copies of the next-state decode, so they line up with state_q.
      read_en_d  = (state_d == ST_READ);
      write_en_d = (state_d == ST_MERGE) || (state_d == ST_WRITE);
      done_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         size_q     <= '0;
         read_en_q  <= 1'b0;
         write_en_q <= 1'b0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         size_q     <= size_d;
         read_en_q  <= read_en_d;
         write_en_q <= write_en_d;
         done_q     <= done_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Merge data comes from the memory read port in the MERGE cycle, so this path stays combinational.
   always_comb begin
      write_data = '0;
      if (state_q == ST_MERGE) write_data = merged;
      else if (state_q == ST_WRITE) write_data = data_q;
   end

   assign mem.o_MEM_Addr      = addr_q[ADDRBITS+1:2];
   assign mem.o_MEM_ReadEn    = read_en_q;
   assign mem.o_MEM_WriteEn   = write_en_q;
   assign mem.o_MEM_WriteData = write_data;
   assign mem.o_MEM_Done      = done_q;
   assign mem.o_MEM_Stall     = mem.i_MEM_Store & (state_q != ST_DONE);
`ifdef MEM_ALIGN_CHECK_EN
   assign mem.o_MEM_AddrErr   = addr_err_q;
`else
   logic unused_err;
   assign unused_err = addr_err_q;
`endif

endmodule
